// File: rtl/ex_forwarding_unit.sv
// ex_forwarding_unit: EX-stage ALU operand forwarding selects (00 regfile, 10 EX/M, 01 M/WB).
// Optional forwarding-event counters are built when FWD_STATS_EN is defined.
module ex_forwarding_unit #(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NB_REG-1:0] i_rs_from_ID,
    input  logic [NB_REG-1:0] i_rt_from_ID,
    input  logic [NB_REG-1:0] i_rd_from_M,
    input  logic [NB_REG-1:0] i_rd_from_WB,
    input  logic              i_RegWrite_from_M,
    input  logic              i_RegWrite_from_WB,
    output logic [1:0]        o_forwardA,
    output logic [1:0]        o_forwardB,
    output logic [NB_CNT-1:0] o_fwd_m_count,
    output logic [NB_CNT-1:0] o_fwd_wb_count
);
    logic m_live, wb_live;
    logic m_a, m_b, wb_a, wb_b;

    // $0 is hard-wired zero, so a write to it is never a real producer
    assign m_live  = i_RegWrite_from_M  && |i_rd_from_M;
    assign wb_live = i_RegWrite_from_WB && |i_rd_from_WB;
    assign m_a  = m_live  && i_rd_from_M  == i_rs_from_ID;
    assign m_b  = m_live  && i_rd_from_M  == i_rt_from_ID;
    assign wb_a = wb_live && i_rd_from_WB == i_rs_from_ID;
    assign wb_b = wb_live && i_rd_from_WB == i_rt_from_ID;

    assign o_forwardA = i_rst ? 2'b00 : m_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
    assign o_forwardB = i_rst ? 2'b00 : m_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;

`ifdef FWD_STATS_EN
    logic [NB_CNT-1:0] m_cnt_q, m_cnt_d, wb_cnt_q, wb_cnt_d;
    logic              m_hit, wb_hit;

    assign m_hit  = o_forwardA == 2'b10 || o_forwardB == 2'b10;
    assign wb_hit = o_forwardA == 2'b01 || o_forwardB == 2'b01;

    always_comb begin
        m_cnt_d  = m_cnt_q  + NB_CNT'(m_hit  && !(&m_cnt_q));
        wb_cnt_d = wb_cnt_q + NB_CNT'(wb_hit && !(&wb_cnt_q));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_cnt_q  <= '0;
            wb_cnt_q <= '0;
        end else begin
            m_cnt_q  <= m_cnt_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end

    assign o_fwd_m_count  = m_cnt_q;
    assign o_fwd_wb_count = wb_cnt_q;
`else
    logic unused_clk;

    assign unused_clk     = i_clk;
    assign o_fwd_m_count  = '0;
    assign o_fwd_wb_count = '0;
`endif
endmodule

// File: tb/tb_ex_forwarding_unit.sv
// tb_ex_forwarding_unit: randomized and directed checks of ex_forwarding_unit against a rule-level model.
module tb_ex_forwarding_unit;
`ifdef FWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs = '0, rt = '0, rdm = '0, rdwb = '0;
    logic        wm = 1'b0, wwb = 1'b0;
    logic [1:0]  fa, fb;
    logic [15:0] cm, cwb;
    int          errors = 0;
    int          checks = 0;
    int          exp_m = 0;
    int          exp_wb = 0;

    ex_forwarding_unit dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs_from_ID(rs), .i_rt_from_ID(rt),
        .i_rd_from_M(rdm), .i_rd_from_WB(rdwb),
        .i_RegWrite_from_M(wm), .i_RegWrite_from_WB(wwb),
        .o_forwardA(fa), .o_forwardB(fb),
        .o_fwd_m_count(cm), .o_fwd_wb_count(cwb)
    );

    always #5 clk = ~clk;

    // Newest writing producer of a source register wins; $0 never has a producer.
    function automatic logic [1:0] ref_sel(input logic [4:0] src);
        logic [4:0] dst [2];
        logic       wr  [2];
        logic [1:0] code [2];
        dst = '{rdm, rdwb};
        wr = '{wm, wwb};
        code = '{2'b10, 2'b01};
        if (rst || src == 5'd0) return 2'b00;
        for (int s = 0; s < 2; s++)
            if (wr[s] && dst[s] == src) return code[s];
        return 2'b00;
    endfunction

    task automatic drive(input logic [4:0] a, b, m, w, input logic em, ew);
        rs = a; rt = b; rdm = m; rdwb = w; wm = em; wwb = ew;
    endtask

    task automatic tick();
        logic [1:0] a, b;
        a = ref_sel(rs);
        b = ref_sel(rt);
        @(posedge clk);
        if (STATS && !rst) begin
            if ((a == 2'b10 || b == 2'b10) && exp_m < CMAX) exp_m++;
            if ((a == 2'b01 || b == 2'b01) && exp_wb < CMAX) exp_wb++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(5'd4, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1);
        #1;
        checks++;
        if (fa !== 2'b00 || fb !== 2'b00) begin
            errors++;
            $display("FAIL reset_fwd: A=%b B=%b, required 00 00", fa, fb);
        end
        tick();
        tick();
        checks++;
        if (cm !== 16'd0 || cwb !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: m=%0d wb=%0d, required 0 0", cm, cwb);
        end
        rst = 1'b0;
        exp_m = 0;
        exp_wb = 0;
    endtask

    task automatic test_directed();
        logic [4:0] v [7][4];
        logic [1:0] we [7];
        logic [1:0] ea [7];
        logic [1:0] eb [7];
        v  = '{'{1,2,3,4}, '{3,2,3,4}, '{1,4,3,4}, '{4,4,4,4}, '{0,7,0,9}, '{1,2,5,6}, '{3,3,3,0}};
        we = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
        ea = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        eb = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 7; i++) begin
            drive(v[i][0], v[i][1], v[i][2], v[i][3], we[i][1], we[i][0]);
            #1;
            checks++;
            if (fa !== ea[i] || fb !== eb[i]) begin
                errors++;
                $display("FAIL directed_%0d: A=%b B=%b, required %b %b", i, fa, fb, ea[i], eb[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [1:0] a, b;
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            if (i % 16 == 0) rt = 5'($urandom);
            #1;
            a = ref_sel(rs);
            b = ref_sel(rt);
            checks++;
            if (fa !== a || fb !== b) begin
                errors++;
                $display("FAIL random_%0d: A=%b B=%b, required %b %b", i, fa, fb, a, b);
            end
            tick();
        end
        #1;
        checks++;
        if (cm !== 16'(exp_m) || cwb !== 16'(exp_wb)) begin
            errors++;
            $display("FAIL random_cnt: m=%0d wb=%0d, required %0d %0d", cm, cwb, exp_m, exp_wb);
        end
    endtask

    task automatic test_stats();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_m = 0;
        exp_wb = 0;
        drive(5'd4, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1);
        repeat (3) tick();
        #1;
        checks++;
        if (cm !== 16'(exp_m) || cwb !== 16'd0 || (STATS && cm !== 16'd3)) begin
            errors++;
            $display("FAIL stats_hold3: m=%0d wb=%0d, required %0d 0", cm, cwb, exp_m);
        end
        drive(5'd4, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        repeat (2) tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (cm !== 16'd0 || cwb !== 16'd0) begin
            errors++;
            $display("FAIL stats_async_rst: m=%0d wb=%0d, required 0 0", cm, cwb);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_m = 0;
        exp_wb = 0;
    endtask

    task automatic test_saturation();
        drive(5'd6, 5'd0, 5'd6, 5'd9, 1'b1, 1'b0);
        repeat (CMAX + 4) tick();
        #1;
        checks++;
        if (cm !== 16'(exp_m) || cwb !== 16'd0) begin
            errors++;
            $display("FAIL saturate: m=%0d wb=%0d, required %0d 0", cm, cwb, exp_m);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stats();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
